// File: rtl/mod16_down_timer.sv
// Loadable down-counting timer with one-shot and auto-reload modes.
// Emits a one-cycle tc pulse on each expiry and counts pulses since the last start.
module mod16_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             periodic,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic [WIDTH-1:0] tc_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic             mode;

    // Priority: abort > start > pause > countdown. A load of 0 wraps to all ones,
    // which is how a period of 2^WIDTH is encoded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= ZERO;
            busy     <= 1'b0;
            tc       <= 1'b0;
            done     <= 1'b0;
            tc_count <= ZERO;
            reload   <= ZERO;
            mode     <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            count    <= ZERO;
            busy     <= 1'b0;
            tc       <= 1'b0;
            done     <= 1'b0;
            tc_count <= ZERO;
        end else if (start) begin
            state    <= RUN;
            count    <= load_val - ONE;
            reload   <= load_val;
            mode     <= periodic;
            busy     <= 1'b1;
            tc       <= 1'b0;
            done     <= 1'b0;
            tc_count <= ZERO;
        end else begin
            tc <= 1'b0;
            case (state)
                RUN: begin
                    if (!pause) begin
                        if (count != ZERO) begin
                            count <= count - ONE;
                        end else begin
                            tc       <= 1'b1;
                            tc_count <= tc_count + ONE;
                            if (mode) begin
                                count <= reload - ONE;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                IDLE, DONE: begin
                    // Parked: outputs hold until start or abort.
                end
                default: begin
                    state <= IDLE;
                    count <= ZERO;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod16_down_timer.sv
// Self-checking bench for mod16_down_timer: directed scenarios plus randomized
// traffic compared against a cycles-remaining reference model.
module tb_mod16_down_timer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] load_val;
    logic       periodic;
    logic       pause;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic       done;
    logic [3:0] tc_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges left until expiry, period length and pulse total.
    int m_left, m_n, m_pulses;
    bit m_run, m_fin, m_per, m_tc;

    mod16_down_timer #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .load_val (load_val),
        .periodic (periodic),
        .pause    (pause),
        .abort    (abort),
        .count    (count),
        .busy     (busy),
        .tc       (tc),
        .done     (done),
        .tc_count (tc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_left = 1; m_n = 16; m_pulses = 0;
        m_run = 0; m_fin = 0; m_per = 0; m_tc = 0;
    endtask

    task automatic model_step();
        m_tc = 0;
        if (abort) begin
            m_run = 0; m_fin = 0; m_pulses = 0;
        end else if (start) begin
            m_n = (load_val == 0) ? 16 : int'(load_val);
            m_per = periodic; m_left = m_n; m_pulses = 0;
            m_run = 1; m_fin = 0;
        end else if (m_run && !pause) begin
            if (m_left > 1) m_left--;
            else begin
                m_tc = 1; m_pulses++;
                if (m_per) m_left = m_n;
                else begin m_run = 0; m_fin = 1; end
            end
        end
    endtask

    function automatic logic [3:0] m_count();
        return m_run ? 4'(m_left - 1) : 4'd0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; pause = 0; abort = 0;
    endtask

    task automatic do_start(input logic [3:0] lv, input logic per);
        load_val = lv; periodic = per; start = 1;
        cycle();
        start = 0;
        load_val = 4'($urandom);
        periodic = 1'($urandom);
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs(); load_val = 4'd7; periodic = 1;
        model_reset();
        #12;
        n_checks++;
        if ({count, busy, tc, done, tc_count} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state: got count=%0d busy=%b tc=%b done=%b tc_count=%0d, want all 0",
                     count, busy, tc, done, tc_count);
        end
        #1 reset = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if ({count, busy, tc, done, tc_count} !== 11'd0) begin
                n_fail++;
                $display("FAIL post_reset_quiet[%0d]: got count=%0d busy=%b tc=%b done=%b tc_count=%0d, want all 0",
                         i, count, busy, tc, done, tc_count);
            end
        end
    endtask

    task automatic test_one_shot();
        do_start(4'd5, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            n_checks++;
            if (count !== 4'(i) || tc !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL oneshot_count: got count=%0d tc=%b busy=%b, want count=%0d tc=0 busy=1",
                         count, tc, busy, i);
            end
            if (i != 0) cycle();
        end
        cycle();
        n_checks++;
        if (tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || count !== 4'd0 || tc_count !== 4'd1) begin
            n_fail++;
            $display("FAIL oneshot_expire: got tc=%b done=%b busy=%b count=%0d tc_count=%0d, want 1 1 0 0 1",
                     tc, done, busy, count, tc_count);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (tc !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || count !== 4'd0) begin
                n_fail++;
                $display("FAIL oneshot_hold: got tc=%b done=%b busy=%b count=%0d, want 0 1 0 0",
                         tc, done, busy, count);
            end
        end
    endtask

    task automatic test_periodic();
        do_start(4'd3, 1'b1);
        for (int c = 1; c <= 51; c++) begin
            cycle();
            n_checks++;
            if (tc !== ((c % 3) == 0) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL periodic_tc[%0d]: got tc=%b busy=%b, want tc=%b busy=1",
                         c, tc, busy, (c % 3) == 0);
            end
        end
        n_checks++;
        if (tc_count !== 4'd1) begin
            n_fail++;
            $display("FAIL periodic_wrap: got tc_count=%0d, want 1", tc_count);
        end
        abort = 1; cycle(); abort = 0;
    endtask

    task automatic test_n16();
        do_start(4'd0, 1'b0);
        n_checks++;
        if (count !== 4'd15) begin
            n_fail++;
            $display("FAIL n16_first: got count=%0d, want 15", count);
        end
        for (int c = 1; c <= 16; c++) begin
            cycle();
            n_checks++;
            if (tc !== (c == 16)) begin
                n_fail++;
                $display("FAIL n16_tc[%0d]: got tc=%b, want %b", c, tc, c == 16);
            end
        end
    endtask

    task automatic test_pause();
        do_start(4'd4, 1'b0);
        cycle();
        n_checks++;
        if (count !== 4'd2) begin
            n_fail++;
            $display("FAIL pause_setup: got count=%0d, want 2", count);
        end
        pause = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (count !== 4'd2 || tc !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL pause_hold[%0d]: got count=%0d tc=%b busy=%b, want 2 0 1", i, count, tc, busy);
            end
        end
        pause = 0;
        // Unpaused, tc would follow edge 4 after start; three frozen edges push it to edge 7.
        for (int e = 5; e <= 7; e++) begin
            cycle();
            n_checks++;
            if (tc !== (e == 7)) begin
                n_fail++;
                $display("FAIL pause_delay[edge %0d]: got tc=%b count=%0d, want tc=%b", e, tc, count, e == 7);
            end
        end
    endtask

    task automatic test_abort_vs_start();
        do_start(4'd9, 1'b1);
        cycle(); cycle();
        abort = 1; start = 1; load_val = 4'd6;
        cycle();
        abort = 0; start = 0;
        n_checks++;
        if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || tc_count !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_wins: got count=%0d busy=%b done=%b tc_count=%0d, want 0 0 0 0",
                     count, busy, done, tc_count);
        end
        do_start(4'd3, 1'b0);
        cycle(); cycle();
        n_checks++;
        if (count !== 4'd0) begin
            n_fail++;
            $display("FAIL retrigger_setup: got count=%0d, want 0", count);
        end
        do_start(4'd2, 1'b0);
        n_checks++;
        if (tc !== 1'b0 || count !== 4'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL retrigger: got tc=%b count=%0d busy=%b, want 0 1 1", tc, count, busy);
        end
        cycle(); cycle();
        n_checks++;
        if (tc !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL retrigger_expire: got tc=%b done=%b, want 1 1", tc, done);
        end
    endtask

    task automatic test_async_reset();
        do_start(4'd9, 1'b1);
        for (int i = 0; i < 10; i++) cycle();
        n_checks++;
        if (count !== 4'd7 || tc_count !== 4'd1) begin
            n_fail++;
            $display("FAIL areset_setup: got count=%0d tc_count=%0d, want 7 1", count, tc_count);
        end
        #2 reset = 1;
        model_reset();
        #1;
        n_checks++;
        if ({count, busy, tc, done, tc_count} !== 11'd0) begin
            n_fail++;
            $display("FAIL areset_immediate: got count=%0d busy=%b tc=%b done=%b tc_count=%0d, want all 0",
                     count, busy, tc, done, tc_count);
        end
        #3 reset = 0;
        for (int i = 0; i < 12; i++) begin
            load_val = 4'($urandom); periodic = 1'($urandom); pause = 1'($urandom);
            cycle();
            n_checks++;
            if (busy !== 1'b0 || tc !== 1'b0 || count !== 4'd0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL areset_idle[%0d]: got busy=%b tc=%b count=%0d done=%b, want 0 0 0 0",
                         i, busy, tc, count, done);
            end
        end
        pause = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            abort    = ($urandom_range(0, 39) == 0);
            start    = ($urandom_range(0, 11) == 0);
            pause    = ($urandom_range(0, 4) == 0);
            load_val = 4'($urandom);
            periodic = 1'($urandom);
            cycle();
            n_checks++;
            if (count !== m_count() || tc !== m_tc || busy !== m_run || done !== m_fin
                || tc_count !== 4'(m_pulses % 16)) begin
                n_fail++;
                $display("FAIL random[%0d]: got count=%0d tc=%b busy=%b done=%b tc_count=%0d, want %0d %b %b %b %0d",
                         i, count, tc, busy, done, tc_count,
                         m_count(), m_tc, m_run, m_fin, m_pulses % 16);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_n16();
        test_pause();
        test_abort_vs_start();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
